uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver. It is the receive-side counterpart to the team's uart_tx and uses the same frame format.
- Frame format: 1 start bit (low), 8 data bits LSB first, 1 even-parity bit, 2 stop bits (high). The parity bit equals the XOR of the 8 data bits.
- Sits between the board RX pin and the puzzle-input loader. It delivers bytes with a valid/ack handshake and per-byte error flags.
- Bit timing comes from CLK_FREQ and BAUD_RATE in the params package.

Parameters:
- CYCLES_PER_BIT, default CLK_FREQ / BAUD_RATE: clock cycles per bit period. Must be >= 4.
- HALF_BIT, default CYCLES_PER_BIT / 2: delay from the start edge to the start-bit midpoint.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idles high
- data  output  8  received byte; valid only while `valid`=1
- valid  output  1  byte available; held until acknowledged
- ack  input  1  consumer accepts the byte; only meaningful while `valid`=1
- parity_err  output  1  parity mismatch on the held byte
- frame_err  output  1  either stop bit sampled low on the held byte
- overrun  output  1  sticky; a frame completed while `valid`=1; cleared only by rst
- busy  output  1  high from start detect until the return to IDLE

Behaviour:
- **Clocking and reset.** One clock, `clk`. Reset is synchronous and active-high on `rst`.
  - On rst: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchroniser flops=1.
  - Reset mid-frame abandons the frame and produces no valid.
- **Input synchronisation.** `rx` passes through a 2-flop synchroniser. All decisions use the synchronised signal rxs, which lags `rx` by 2 cycles.
- **Bit counter.** A counter of at least 16 bits counts bit periods. A 4-bit index tracks the current bit.
- **States:**
  - IDLE: busy=0. rxs=0 -> START with counter cleared.
  - START: at counter == HALF_BIT-1, sample rxs.
    - rxs=1: glitch, go to IDLE, no flags raised.
    - rxs=0: go to DATA with counter cleared.
  - DATA: sample rxs at each counter == CYCLES_PER_BIT-1 into shift register bit [index]. Index counts 0..7; after index 7 go to PARITY.
  - PARITY: sample one bit at the same point.
  - STOP1, STOP2: sample one bit each at the same point.
    - Any stop sample of 0 sets the pending frame error.
    - After the STOP2 sample, complete the frame and go to IDLE the same cycle.
  - In every non-IDLE state, counter != terminal -> counter+1.
- **Frame completion** (the cycle of the STOP2 sample):
  - valid=0: on the next edge, data <= shift register, parity_err <= (parity sample != ^data), frame_err <= pending frame error, valid <= 1.
  - valid=1 and no ack that same cycle: overrun <= 1. The new byte is dropped; held data and flags are unchanged.
  - valid=1 and ack that same cycle: ack wins first, then the new byte loads. valid stays 1 and no overrun is raised.
- **Handshake.**
  - ack while valid=1 -> valid <= 0 next cycle. The error flags clear together with valid.
  - ack while valid=0 is ignored.
- **Latency and back-to-back frames.**
  - Latency from the rx falling edge to valid high: 2 + HALF_BIT + 11*CYCLES_PER_BIT + 1 cycles.
  - Because the return to IDLE happens at mid-STOP2, a start bit that follows immediately is detected.
- **Line stuck low.** Frame completes with frame_err=1. The receiver then re-enters START on the continuing low.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 rxs samples taken at counter == terminal-1, terminal, and terminal+1.
  - In START and IDLE the sampling points are taken relative to HALF_BIT instead.
  - The decision is registered one cycle after the last sample. All state transitions and valid are delayed by exactly 1 cycle.
- Undefined: single sample at the terminal count, as in Behaviour.

Test Plan:
- **Clean byte.** CYCLES_PER_BIT=16; send 0xA5 with parity 0 and stop bits 1,1 -> valid=1, data=0xA5, parity_err=0, frame_err=0, exactly 2+8+176+1=187 cycles after the falling edge.
- **Parity error.** Send 0x01 with parity bit forced to 0 -> valid=1, data=0x01, parity_err=1. ack -> valid, parity_err=0 next cycle.
- **Framing error.** Send 0x3C with the second stop bit low -> frame_err=1, data=0x3C. The receiver re-enters START on the still-low line.
- **Glitch.** rx low for 5 cycles, then high -> no valid, busy falls at START sample (cycle 2+8), state=IDLE.
- **Overrun.** Send 0x11 and 0x22 back-to-back without ack -> data=0x11 held, overrun=1. Repeat with ack asserted on the STOP2-sample cycle -> data=0x22, overrun=0.
- **Reset mid-frame.** rst pulse during DATA bit 4, then send 0x7E -> no valid for the aborted frame, then data=0x7E, valid=1, all flags 0.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side byte interface of uart_rx.
// The receiver (master) drives the byte, its flags and busy.
// The consumer (slave) drives the serial line and ack.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx, ack,
    output data, valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output rx, ack,
    input  data, valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 8E2 frames.
// Frame format: start(0), 8 data bits LSB first, even parity, two stop bits(1).
// Bytes are held on a valid/ack handshake, with parity and framing error flags.
// overrun is sticky and is cleared only by rst.
// Optional macro UART_RX_MAJORITY_EN: each bit becomes a 3-sample majority
// vote around the sampling point, and the whole FSM runs one cycle later.
module uart_rx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_ferr_pend;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_perr;
  logic                r_ferr;
  logic                r_overrun;
  logic                r_busy;
  logic                r_rx_p0;
  logic                r_rx_p1;
  logic                w_line;
  logic                w_bit;
  logic                w_bit_tick;

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_p2;
  logic r_rx_p3;

  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Extra delay taps: the FSM looks at the p2 stream, so p3/p2/p1 are the
  // samples one before, at and one after its sampling point.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_p2 <= 1'b1;
      r_rx_p3 <= 1'b1;
    end else begin
      r_rx_p2 <= r_rx_p1;
      r_rx_p3 <= r_rx_p2;
    end
  end

  assign w_line = r_rx_p2;
  assign w_bit  = f_majority(r_rx_p3, r_rx_p2, r_rx_p1);
`else
  assign w_line = r_rx_p1;
  assign w_bit  = r_rx_p1;
`endif

  assign w_bit_tick = (r_cnt == BIT_LAST);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_p0 <= 1'b1;
      r_rx_p1 <= 1'b1;
    end else begin
      r_rx_p0 <= bus.rx;
      r_rx_p1 <= r_rx_p0;
    end
  end

  // Receive FSM, byte holding register and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_ferr_pend <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Consumer accepts the held byte; flags go with it
      if (r_valid && bus.ack) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            if (w_bit) begin
              // Start bit did not hold to its midpoint: treat as a glitch
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= S_DATA;
              r_cnt       <= '0;
              r_idx       <= '0;
              r_ferr_pend <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_tick) begin
            r_cnt                <= '0;
            r_shift[r_idx[2:0]]  <= w_bit;
            if (r_idx == 4'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_par   <= w_bit;
            r_state <= S_STOP1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_STOP1: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_state <= S_STOP2;
            if (!w_bit) begin
              r_ferr_pend <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_STOP2: begin
          if (w_bit_tick) begin
            // Leave at mid-stop so an immediately following start bit is seen
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_valid || bus.ack) begin
              // Same-cycle ack frees the holding register for the new byte
              r_data  <= r_shift;
              r_perr  <= (r_par != ^r_shift);
              r_ferr  <= r_ferr_pend | ~w_bit;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with 16 cycles per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vc1;
  int   vc2;

  uart_rx_if u_if ();

  uart_rx #(
    .CYCLES_PER_BIT(16),
    .HALF_BIT(8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    u_if.ack = 1'b1;
    tick(1);
    u_if.ack = 1'b0;
  endtask

  // Drive one 12-bit frame, 16 cycles per bit, starting just after a clock edge.
  // vc = cycle (edges after the start-bit falling edge) at which valid rose, -1 if never.
  // ack_at > 0: ack is high only during the cycle ending at edge ack_at.
  // abort_at > 0: after edge abort_at, pulse rst for one cycle and stop sending.
  // rx is left at the last driven bit value.
  task automatic send(input logic [7:0] d, input logic p, input logic s1, input logic s2,
                      input int ack_at, input int abort_at, output int vc);
    logic [11:0] bits;
    logic        prev;
    logic        aborted;
    int          k;
    bits    = {s2, s1, p, d, 1'b0};
    vc      = -1;
    k       = 0;
    prev    = u_if.valid;
    aborted = 1'b0;
    for (int b = 0; b < 12 && !aborted; b++) begin
      u_if.rx = bits[b];
      for (int c = 0; c < 16 && !aborted; c++) begin
        @(posedge clk);
        #1;
        k++;
        if (u_if.valid && !prev && vc < 0) vc = k;
        prev = u_if.valid;
        if (ack_at > 0) u_if.ack = (k == ack_at - 1);
        if (abort_at > 0 && k == abort_at) begin
          u_if.rx = 1'b1;
          rst     = 1'b1;
          tick(1);
          rst     = 1'b0;
          aborted = 1'b1;
        end
      end
    end
  endtask

  initial begin
    u_if.rx  = 1'b1;
    u_if.ack = 1'b0;
    rst      = 1'b1;
    tick(3);

    // Reset state
    check("rst_valid", u_if.valid, 0);
    check("rst_data", u_if.data, 0);
    check("rst_perr", u_if.parity_err, 0);
    check("rst_ferr", u_if.frame_err, 0);
    check("rst_overrun", u_if.overrun, 0);
    check("rst_busy", u_if.busy, 0);
    rst = 1'b0;
    tick(5);

    // Clean byte 0xA5, parity 0
    send(8'hA5, 1'b0, 1'b1, 1'b1, 0, 0, vc1);
    check("clean_latency", vc1, 187);
    check("clean_valid", u_if.valid, 1);
    check("clean_data", u_if.data, 8'hA5);
    check("clean_perr", u_if.parity_err, 0);
    check("clean_ferr", u_if.frame_err, 0);
    check("clean_busy", u_if.busy, 0);
    do_ack();
    check("clean_ack_valid", u_if.valid, 0);
    tick(4);

    // Parity error: 0x01 needs parity 1, send 0
    send(8'h01, 1'b0, 1'b1, 1'b1, 0, 0, vc1);
    check("par_valid", u_if.valid, 1);
    check("par_data", u_if.data, 8'h01);
    check("par_perr", u_if.parity_err, 1);
    check("par_ferr", u_if.frame_err, 0);
    do_ack();
    check("par_ack_valid", u_if.valid, 0);
    check("par_ack_perr", u_if.parity_err, 0);
    tick(4);

    // Framing error: 0x3C with second stop bit low, line stays low afterwards
    send(8'h3C, 1'b0, 1'b1, 1'b0, 0, 0, vc1);
    check("frm_latency", vc1, 187);
    check("frm_data", u_if.data, 8'h3C);
    check("frm_ferr", u_if.frame_err, 1);
    check("frm_perr", u_if.parity_err, 0);
    check("frm_restart_busy", u_if.busy, 1);
    u_if.rx = 1'b1;
    tick(20);
    check("frm_glitch_idle", u_if.busy, 0);
    check("frm_held_valid", u_if.valid, 1);
    do_ack();
    check("frm_ack_valid", u_if.valid, 0);
    check("frm_ack_ferr", u_if.frame_err, 0);
    tick(4);

    // Glitch: 5 cycles low
    u_if.rx = 1'b0;
    tick(5);
    check("glitch_busy_hi", u_if.busy, 1);
    u_if.rx = 1'b1;
    tick(7);
    check("glitch_busy_lo", u_if.busy, 0);
    tick(30);
    check("glitch_no_valid", u_if.valid, 0);

    // Overrun: two back-to-back frames, no ack
    send(8'h11, 1'b0, 1'b1, 1'b1, 0, 0, vc1);
    send(8'h22, 1'b0, 1'b1, 1'b1, 0, 0, vc2);
    check("ovr_first_latency", vc1, 187);
    check("ovr_data_held", u_if.data, 8'h11);
    check("ovr_valid", u_if.valid, 1);
    check("ovr_flag", u_if.overrun, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("ovr_rst_clear", u_if.overrun, 0);
    check("ovr_rst_valid", u_if.valid, 0);
    tick(4);

    // Back-to-back again, ack on the second frame's STOP2-sample cycle
    send(8'h11, 1'b0, 1'b1, 1'b1, 0, 0, vc1);
    send(8'h22, 1'b0, 1'b1, 1'b1, 187, 0, vc2);
    u_if.ack = 1'b0;
    check("ack_win_data", u_if.data, 8'h22);
    check("ack_win_valid", u_if.valid, 1);
    check("ack_win_overrun", u_if.overrun, 0);
    check("ack_win_no_rise", vc2, 32'hFFFF_FFFF);
    do_ack();
    check("ack_win_cleared", u_if.valid, 0);
    tick(4);

    // Reset mid-frame during data bit 4, then a full 0x7E
    send(8'h7E, 1'b0, 1'b1, 1'b1, 0, 88, vc1);
    tick(40);
    check("abort_no_valid", u_if.valid, 0);
    check("abort_busy", u_if.busy, 0);
    send(8'h7E, 1'b0, 1'b1, 1'b1, 0, 0, vc1);
    check("abort_next_latency", vc1, 187);
    check("abort_next_data", u_if.data, 8'h7E);
    check("abort_next_valid", u_if.valid, 1);
    check("abort_next_perr", u_if.parity_err, 0);
    check("abort_next_ferr", u_if.frame_err, 0);
    check("abort_next_overrun", u_if.overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
